// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into one-cycle press/release/short/long/double
// events plus a held level. One shared counter times both the long and double windows.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DOUBLE_CYCLES = 25_000_000,
    parameter int CNT_WIDTH     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic press_tick,
    output logic release_tick,
    output logic short_tick,
    output logic long_tick,
    output logic double_tick,
    output logic held
);

    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DOUBLE_LAST = CNT_WIDTH'(DOUBLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        SECOND    = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   db_q;
    logic                   rise, fall;
    logic                   short_nxt, long_nxt, double_nxt;

    // db_q resets high so a button held through reset never reports a press.
    assign rise = db_in & ~db_q;
    assign fall = ~db_in & db_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESSED: begin
                // Release has priority over reaching the long threshold.
                if (!db_in) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!db_in) state_nxt = IDLE;
            end
            WAIT2: begin
                // A second press on the last window cycle still counts as double.
                if (db_in) begin
                    state_nxt  = SECOND;
                    double_nxt = 1'b1;
                end else if (cnt == DOUBLE_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SECOND: begin
                if (!db_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            db_q         <= 1'b1;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            short_tick   <= 1'b0;
            long_tick    <= 1'b0;
            double_tick  <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            db_q         <= db_in;
            press_tick   <= rise;
            release_tick <= fall;
            short_tick   <= short_nxt;
            long_tick    <= long_nxt;
            double_tick  <= double_nxt;
            held         <= (state_nxt == LONG_HELD);
        end
    end

endmodule
